f2sdram_burst_writer: RTL and testbench

Streaming-to-Avalon-MM burst write master for the f2sdram path. Accepts a valid/ready stream of DATA_WIDTH words from core logic, buffers it, and issues fixed-length Avalon-MM write bursts to a linear SDRAM region. Its master port connects directly to the slave side of the f2sdram safe terminator. Every burst is issued only once all of its data is already buffered, so `write` stays asserted for the whole burst and never stalls mid-transaction.

---
 rtl/f2sdram_pkg.sv | 15 +
 rtl/f2sdram_wr_fifo.sv | 44 ++++
 rtl/f2sdram_burst_writer.sv | 130 +++++++++++++
 tb/tb_f2sdram_burst_writer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/f2sdram_pkg.sv
// rtl/f2sdram_pkg.sv - shared state type and default widths for the f2sdram write path
package f2sdram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        BURST  = 2'd2,
        FINISH = 2'd3
    } wr_state_t;

    localparam int DEF_ADDRESS_WIDTH    = 29;
    localparam int DEF_DATA_WIDTH       = 64;
    localparam int DEF_BURSTCOUNT_WIDTH = 8;

endpackage

// File: rtl/f2sdram_wr_fifo.sv
// rtl/f2sdram_wr_fifo.sv - show-ahead buffer with occupancy count for the burst writer
module f2sdram_wr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [PW:0]      count,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit distinguishes full from empty.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/f2sdram_burst_writer.sv
// rtl/f2sdram_burst_writer.sv - stream to Avalon-MM fixed-burst write master for f2sdram
module f2sdram_burst_writer
    import f2sdram_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int BURSTCOUNT_WIDTH = DEF_BURSTCOUNT_WIDTH,
    parameter int BYTEENABLE_WIDTH = DATA_WIDTH / 8,
    parameter int BURST_LEN        = 16,
    parameter int FIFO_DEPTH       = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDRESS_WIDTH-1:0]    base_addr,
    input  logic [31:0]                 length,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        in_ready,
    output logic                        busy,
    output logic                        done,
    input  logic                        waitrequest,
    output logic [BURSTCOUNT_WIDTH-1:0] burstcount,
    output logic [ADDRESS_WIDTH-1:0]    address,
    output logic [DATA_WIDTH-1:0]       writedata,
    output logic [BYTEENABLE_WIDTH-1:0] byteenable,
    output logic                        write
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]    addr_q;
    logic [31:0]                 remaining_q;
    logic [31:0]                 length_q;
    logic [31:0]                 accepted_q;
    logic [BURSTCOUNT_WIDTH-1:0] beat_q;
    logic [31:0]                 burst_len;
    logic [CW-1:0]               fifo_count;
    logic                        fifo_full;
    logic                        push;
    logic                        pop;
    logic                        load_burst;
    logic                        last_beat;

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FINISH);
    assign in_ready   = busy && !fifo_full && (accepted_q < length_q);
    assign push       = in_valid && in_ready;
    assign pop        = write && !waitrequest;
    assign byteenable = '1;
    assign burst_len  = (remaining_q < 32'(BURST_LEN)) ? remaining_q : 32'(BURST_LEN);

    f2sdram_wr_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (in_data),
        .pop   (pop),
        .dout  (writedata),
        .count (fifo_count),
        .full  (fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        load_burst = 1'b0;
        last_beat  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (length == 32'd0) ? FINISH : FILL;
            end
            FILL: begin
                // A burst only launches once every beat is already buffered.
                if (32'(fifo_count) >= burst_len) begin
                    load_burst = 1'b1;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (pop && (beat_q == burstcount - BURSTCOUNT_WIDTH'(1))) begin
                    last_beat = 1'b1;
                    state_d   = (remaining_q == 32'(burstcount)) ? FINISH : FILL;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            length_q    <= '0;
            accepted_q  <= '0;
            beat_q      <= '0;
            burstcount  <= BURSTCOUNT_WIDTH'(1);
            address     <= '0;
            write       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                addr_q      <= base_addr;
                remaining_q <= length;
                length_q    <= length;
                accepted_q  <= '0;
            end
            if (push) accepted_q <= accepted_q + 32'd1;
            if (load_burst) begin
                address    <= addr_q;
                burstcount <= burst_len[BURSTCOUNT_WIDTH-1:0];
                beat_q     <= '0;
                write      <= 1'b1;
            end else if (pop) begin
                beat_q <= beat_q + BURSTCOUNT_WIDTH'(1);
            end
            if (last_beat) begin
                write       <= 1'b0;
                addr_q      <= addr_q + ADDRESS_WIDTH'(burstcount);
                remaining_q <= remaining_q - 32'(burstcount);
            end
        end
    end

endmodule

// File: tb/tb_f2sdram_burst_writer.sv
// tb/tb_f2sdram_burst_writer.sv - randomized self-checking bench for f2sdram_burst_writer
module tb_f2sdram_burst_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [28:0] base_addr;
    logic [31:0] length;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        waitrequest;
    logic [7:0]  burstcount;
    logic [28:0] address;
    logic [63:0] writedata;
    logic [7:0]  byteenable;
    logic        write;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    f2sdram_burst_writer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .done        (done),
        .waitrequest (waitrequest),
        .burstcount  (burstcount),
        .address     (address),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .write       (write)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [28:0] base, input int len);
        start     = 1'b1;
        base_addr = base;
        length    = 32'(len);
        step();
        start     = 1'b0;
        base_addr = $urandom;
        length    = $urandom;
    endtask

    // Reference: burst i covers words [16i, 16i+min(16,len-16i)) at base+16i (mod 2^29).
    task automatic run_xfer(input logic [28:0] base, input int len, input int wait_pct, input int gap);
        logic [63:0] words[$];
        int          acc = 0, beats = 0, bursts = 0, bbeat = 0, exp_cnt = 0;
        int          cyc = 0, last_beat_cyc = -10;
        bit          seen_done = 0, expect_low = 0;
        logic        p_write = 0, p_wait = 0;
        logic [28:0] p_addr = '0;
        logic [7:0]  p_bc = '0;
        logic [28:0] exp_addr;

        pulse_start(base, len);
        chk("busy_after_start", busy, 1'b1);
        while (!seen_done && cyc < 4000) begin
            in_valid = (gap == 0) ? 1'b1 : ((cyc % gap) == 0);
            while (words.size() <= acc) words.push_back({$urandom, $urandom});
            in_data     = words[acc];
            waitrequest = write ? ($urandom_range(99) < wait_pct) : 1'($urandom_range(1));

            if (done) begin
                seen_done = 1;
                chk("done_latency", 64'(cyc - last_beat_cyc), 64'd1);
                chk("beats_total", 64'(beats), 64'(len));
                chk("accepted_total", 64'(acc), 64'(len));
                chk("write_at_done", write, 1'b0);
            end
            if (expect_low) begin
                chk("inter_burst_gap", write, 1'b0);
                expect_low = 0;
            end
            if (write && !p_write) begin
                exp_cnt  = (len - 16 * bursts < 16) ? len - 16 * bursts : 16;
                exp_addr = base + 29'(16 * bursts);
                chk("burst_addr", address, exp_addr);
                chk("burst_count", burstcount, 8'(exp_cnt));
                chk("buffered_before_write", 64'(acc - beats >= exp_cnt), 64'd1);
                chk("byteenable", byteenable, 8'hFF);
                bbeat = 0;
            end
            if (p_write && p_wait) begin
                chk("wait_hold_write", write, 1'b1);
                chk("wait_hold_addr", address, p_addr);
                chk("wait_hold_bc", burstcount, p_bc);
            end
            if (write && !waitrequest) begin
                chk("writedata", writedata, (beats < words.size()) ? words[beats] : 64'hX);
                beats++;
                bbeat++;
                last_beat_cyc = cyc;
                if (bbeat == exp_cnt) begin
                    bursts++;
                    expect_low = 1;
                end
            end
            if (in_valid && in_ready) acc++;
            p_write = write;
            p_wait  = waitrequest;
            p_addr  = address;
            p_bc    = burstcount;
            step();
            cyc++;
        end
        chk("done_seen", 64'(seen_done), 64'd1);
        in_valid = 1'b1;
        chk("done_one_cycle", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
        chk("in_ready_after_done", in_ready, 1'b0);
        in_valid    = 1'b0;
        waitrequest = 1'b0;
        step();
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        length      = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        waitrequest = 1'b0;
        repeat (3) step();
        chk("rst_write", write, 1'b0);
        chk("rst_burstcount", burstcount, 8'd1);
        chk("rst_address", address, 29'd0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;
        step();

        run_xfer(29'h100, 32, 0, 0);
        run_xfer(29'h200, 20, 0, 0);
        run_xfer(29'($urandom), 50, 50, 0);
        run_xfer(29'h300, 48, 0, 3);
        run_xfer(29'h1FFFFFF8, 32, 30, 0);
        for (int i = 0; i < 4; i++)
            run_xfer(29'($urandom), $urandom_range(1, 70), $urandom_range(0, 60), $urandom_range(0, 3));

        begin : reset_mid_burst
            int nb = 0;
            int c  = 0;
            pulse_start(29'h400, 32);
            in_valid    = 1'b1;
            waitrequest = 1'b0;
            while (nb < 5 && c < 200) begin
                in_data = {$urandom, $urandom};
                if (write) nb++;
                step();
                c++;
            end
            chk("reached_beat5", 64'(nb), 64'd5);
            #2;
            reset = 1'b1;
            #1;
            chk("rst_mid_write", write, 1'b0);
            chk("rst_mid_busy", busy, 1'b0);
            chk("rst_mid_in_ready", in_ready, 1'b0);
            step();
            reset    = 1'b0;
            in_valid = 1'b0;
            step();
        end

        begin : zero_length
            bit wrote = 0;
            int dcnt  = 0;
            pulse_start(29'h500, 0);
            for (int k = 0; k < 4; k++) begin
                if (write) wrote = 1;
                if (done) dcnt++;
                step();
            end
            chk("zero_len_done_pulses", 64'(dcnt), 64'd1);
            chk("zero_len_no_write", 64'(wrote), 64'd0);
            chk("zero_len_idle", busy, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
